// File: rtl/z80_io_pkg.sv
// Shared types and register map for the Z80 I/O bus master.
package z80_io_pkg;

  localparam int unsigned WB_W   = 32;
  localparam int unsigned Z80_W  = 8;
  localparam int unsigned CNT_W  = 8;

  // Register offsets from BASE_ADDRESS
  localparam int unsigned CTRL_OFS   = 0;
  localparam int unsigned STATUS_OFS = 4;

  // CTRL layout: {WR[16], DATA[15:8], PORT[7:0]}
  localparam int unsigned CTRL_W = 17;
  typedef struct packed {
    logic              wr;
    logic [Z80_W-1:0]  data;
    logic [Z80_W-1:0]  port;
  } ctrl_t;

  // STATUS bit positions
  localparam int unsigned STS_BUSY      = 0;
  localparam int unsigned STS_DONE      = 1;
  localparam int unsigned STS_TIMEOUT   = 2;
  localparam int unsigned STS_OVERRUN   = 3;
  localparam int unsigned STS_RDATA_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4
  } z80_state_e;

  // Assemble the STATUS read word
  function automatic logic [WB_W-1:0] pack_status(input logic [Z80_W-1:0] rdata,
                                                  input logic overrun,
                                                  input logic timeout,
                                                  input logic done,
                                                  input logic busy);
    logic [WB_W-1:0] w;
    w                           = '0;
    w[STS_RDATA_LSB +: Z80_W]   = rdata;
    w[STS_OVERRUN]              = overrun;
    w[STS_TIMEOUT]              = timeout;
    w[STS_DONE]                 = done;
    w[STS_BUSY]                 = busy;
    return w;
  endfunction

endpackage

// File: rtl/z80_io_master_if.sv
// Wishbone slave bus between a host and the Z80 I/O master.
interface z80_io_master_if;
  import z80_io_pkg::*;

  logic            wb_cyc_in;
  logic            wb_stb_in;
  logic            wb_we_in;
  logic [WB_W-1:0] wb_addr_in;
  logic [WB_W-1:0] wb_data_in;
  logic            wb_ack_out;
  logic [WB_W-1:0] wb_data_out;

  modport master (
    output wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
    input  wb_ack_out, wb_data_out
  );

  modport slave (
    input  wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
    output wb_ack_out, wb_data_out
  );
endinterface

// File: rtl/z80_io_sync.sv
// Two-flop synchroniser for the asynchronous Z80 WAIT input (idles high).
module z80_io_sync (
  input  logic clk,
  input  logic reset_b,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two-stage capture; reset to the inactive (no-wait) level
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/z80_io_master.sv
// Wishbone-controlled Z80 I/O cycle generator (T1/T2/TW/T3 sequencing).
module z80_io_master
  import z80_io_pkg::*;
#(
  parameter logic [WB_W-1:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int unsigned     T_CLKS       = 4,
  parameter int unsigned     WAIT_LIMIT   = 255
) (
  input  logic              clk,
  input  logic              reset_b,
  z80_io_master_if.slave    wb,
  output logic              irq_out,
  output logic [Z80_W-1:0]  z80_address_bus,
  output logic [Z80_W-1:0]  z80_data_bus_out,
  input  logic [Z80_W-1:0]  z80_data_bus_in,
  output logic              z80_bus_dir,
  output logic              z80_ioreq_b,
  output logic              z80_read_strobe_b,
  output logic              z80_write_strobe_b,
  output logic              z80_m1_b,
  input  logic              z80_wait_b
);

  z80_state_e        state_q, state_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [Z80_W-1:0]  rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              ack_q, ack_d;
  logic [WB_W-1:0]   wb_rd_q, wb_rd_d;

  logic [Z80_W-1:0]  addr_d, dout_d;
  logic              dir_d, ioreq_b_d, rd_b_d, wr_b_d;
  logic              active, strobe;

  logic              wait_sync;
  logic              req, hit_ctrl, hit_status, busy, last_t;
  logic              unused_wdata;

  z80_io_sync u_wait_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .d       (z80_wait_b),
    .q       (wait_sync)
  );

  assign req          = wb.wb_cyc_in & wb.wb_stb_in & ~ack_q;
  assign hit_ctrl     = (wb.wb_addr_in == BASE_ADDRESS + WB_W'(CTRL_OFS));
  assign hit_status   = (wb.wb_addr_in == BASE_ADDRESS + WB_W'(STATUS_OFS));
  assign busy         = (state_q != ST_IDLE);
  assign last_t       = (tcnt_q == CNT_W'(T_CLKS - 1));
  assign unused_wdata = ^wb.wb_data_in[WB_W-1:CTRL_W];

  assign wb.wb_ack_out  = ack_q;
  assign wb.wb_data_out = wb_rd_q;
  assign irq_out        = done_q;
  assign z80_m1_b       = 1'b1;

  // Next-state: register access, bus cycle sequencing and pin values
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    wcnt_d    = wcnt_q;
    ctrl_d    = ctrl_q;
    rdata_d   = rdata_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    wb_rd_d   = wb_rd_q;
    ack_d     = req;

    if (req && !wb.wb_we_in) begin
      if (hit_ctrl)
        wb_rd_d = WB_W'(ctrl_q);
      else if (hit_status)
        wb_rd_d = pack_status(rdata_q, overrun_q, timeout_q, done_q, busy);
      else
        wb_rd_d = '0;
    end

    // W1C before the sequencer so a same-clk completion still sets DONE
    if (req && wb.wb_we_in && hit_status) begin
      if (wb.wb_data_in[STS_DONE])    done_d    = 1'b0;
      if (wb.wb_data_in[STS_TIMEOUT]) timeout_d = 1'b0;
      if (wb.wb_data_in[STS_OVERRUN]) overrun_d = 1'b0;
    end

    tcnt_d = (state_q == ST_IDLE || last_t) ? '0 : tcnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: ;
      ST_T1: if (last_t) state_d = ST_T2;
      ST_T2: begin
        if (last_t) begin
          state_d = ST_TW;
          wcnt_d  = '0;
        end
      end
      ST_TW: begin
        if (last_t) begin
          if (wait_sync) begin
            state_d = ST_T3;
          end else if (wcnt_q == CNT_W'(WAIT_LIMIT)) begin
            state_d   = ST_T3;
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
      end
      ST_T3: begin
        if (last_t) begin
          if (!ctrl_q.wr) rdata_d = z80_data_bus_in;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A CTRL write only starts a cycle from IDLE; otherwise it is an overrun
    if (req && wb.wb_we_in && hit_ctrl) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else begin
        ctrl_d    = ctrl_t'(wb.wb_data_in[CTRL_W-1:0]);
        state_d   = ST_T1;
        tcnt_d    = '0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
      end
    end

    active    = (state_d != ST_IDLE);
    strobe    = (state_d == ST_T2) || (state_d == ST_TW) || (state_d == ST_T3);
    addr_d    = active ? ctrl_d.port : '0;
    dir_d     = active && ctrl_d.wr;
    dout_d    = dir_d ? ctrl_d.data : '0;
    ioreq_b_d = ~strobe;
    rd_b_d    = ~(strobe && !ctrl_d.wr);
    wr_b_d    = ~(strobe && ctrl_d.wr);
  end

  // State and registered outputs; reset releases strobes immediately
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q            <= ST_IDLE;
      tcnt_q             <= '0;
      wcnt_q             <= '0;
      ctrl_q             <= '0;
      rdata_q            <= '0;
      done_q             <= 1'b0;
      timeout_q          <= 1'b0;
      overrun_q          <= 1'b0;
      ack_q              <= 1'b0;
      wb_rd_q            <= '0;
      z80_address_bus    <= '0;
      z80_data_bus_out   <= '0;
      z80_bus_dir        <= 1'b0;
      z80_ioreq_b        <= 1'b1;
      z80_read_strobe_b  <= 1'b1;
      z80_write_strobe_b <= 1'b1;
    end else begin
      state_q            <= state_d;
      tcnt_q             <= tcnt_d;
      wcnt_q             <= wcnt_d;
      ctrl_q             <= ctrl_d;
      rdata_q            <= rdata_d;
      done_q             <= done_d;
      timeout_q          <= timeout_d;
      overrun_q          <= overrun_d;
      ack_q              <= ack_d;
      wb_rd_q            <= wb_rd_d;
      z80_address_bus    <= addr_d;
      z80_data_bus_out   <= dout_d;
      z80_bus_dir        <= dir_d;
      z80_ioreq_b        <= ioreq_b_d;
      z80_read_strobe_b  <= rd_b_d;
      z80_write_strobe_b <= wr_b_d;
    end
  end

endmodule

// File: tb/tb_z80_io_master.sv
// Directed bench for z80_io_master: default instance plus a WAIT_LIMIT=2 instance.
module tb_z80_io_master;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] CTRL_A = BASE;
  localparam logic [31:0] STAT_A = BASE + 32'd4;
  localparam logic [31:0] UNM_A  = BASE + 32'd8;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  z80_io_master_if wb0 ();
  z80_io_master_if wb1 ();

  logic [7:0] addr0, dout0, addr1, dout1, din;
  logic dir0, io0, rd0, wr0, m10, wait0, irq0;
  logic dir1, io1, rd1, wr1, m11, wait1, irq1;

  int checks = 0;
  int errors = 0;

  z80_io_master u_dut (
    .clk(clk), .reset_b(reset_b), .wb(wb0), .irq_out(irq0),
    .z80_address_bus(addr0), .z80_data_bus_out(dout0), .z80_data_bus_in(din),
    .z80_bus_dir(dir0), .z80_ioreq_b(io0), .z80_read_strobe_b(rd0),
    .z80_write_strobe_b(wr0), .z80_m1_b(m10), .z80_wait_b(wait0)
  );

  z80_io_master #(.WAIT_LIMIT(2)) u_dut_lim (
    .clk(clk), .reset_b(reset_b), .wb(wb1), .irq_out(irq1),
    .z80_address_bus(addr1), .z80_data_bus_out(dout1), .z80_data_bus_in(din),
    .z80_bus_dir(dir1), .z80_ioreq_b(io1), .z80_read_strobe_b(rd1),
    .z80_write_strobe_b(wr1), .z80_m1_b(m11), .z80_wait_b(wait1)
  );

  // One Wishbone transfer; returns on the negedge where ack is seen
  task automatic wb_xfer(input bit sel, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata);
    bit got;
    got   = 1'b0;
    rdata = '0;
    @(negedge clk);
    if (sel) begin
      wb1.wb_cyc_in = 1; wb1.wb_stb_in = 1; wb1.wb_we_in = we;
      wb1.wb_addr_in = addr; wb1.wb_data_in = wdata;
    end else begin
      wb0.wb_cyc_in = 1; wb0.wb_stb_in = 1; wb0.wb_we_in = we;
      wb0.wb_addr_in = addr; wb0.wb_data_in = wdata;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sel ? wb1.wb_ack_out : wb0.wb_ack_out) begin
        got   = 1'b1;
        rdata = sel ? wb1.wb_data_out : wb0.wb_data_out;
      end
    end
    if (sel) begin wb1.wb_cyc_in = 0; wb1.wb_stb_in = 0; wb1.wb_we_in = 0; end
    else     begin wb0.wb_cyc_in = 0; wb0.wb_stb_in = 0; wb0.wb_we_in = 0; end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wb_ack_timeout addr=%h: ack=0 required=1", addr);
    end
  endtask

  // Counts clocks (sampled on negedge) in which each pin condition holds
  task automatic measure(input bit sel, input int n, input logic [7:0] port, input logic [7:0] data,
                         output int c_addr, output int c_data, output int c_dir, output int c_io,
                         output int c_rd, output int c_wr, output int c_m1);
    c_addr = 0; c_data = 0; c_dir = 0; c_io = 0; c_rd = 0; c_wr = 0; c_m1 = 0;
    for (int i = 0; i < n; i++) begin
      if ((sel ? addr1 : addr0) == port) c_addr++;
      if ((sel ? dir1 : dir0) && (sel ? dout1 : dout0) == data) c_data++;
      if (sel ? dir1 : dir0) c_dir++;
      if (!(sel ? io1 : io0)) c_io++;
      if (!(sel ? rd1 : rd0)) c_rd++;
      if (!(sel ? wr1 : wr0)) c_wr++;
      if (!(sel ? m11 : m10)) c_m1++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (2) @(negedge clk);
    checks++;
    if ({io0, rd0, wr0, m10, dir0} !== 5'b11110) begin
      errors++; $display("FAIL reset_pins: got %b required 11110", {io0, rd0, wr0, m10, dir0});
    end
    checks++;
    if ({addr0, dout0} !== 16'h0000) begin
      errors++; $display("FAIL reset_bus: got %h required 0000", {addr0, dout0});
    end
    checks++;
    if ({wb0.wb_ack_out, irq0} !== 2'b00) begin
      errors++; $display("FAIL reset_ack_irq: got %b required 00", {wb0.wb_ack_out, irq0});
    end
    @(negedge clk);
    reset_b = 1'b1;
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required 00000000", r); end
    wb_xfer(0, 0, CTRL_A, 32'h0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h required 00000000", r); end
  endtask

  task automatic test_write();
    logic [31:0] r;
    int ca, cd, cdir, cio, crd, cwr, cm1;
    wb_xfer(0, 1, CTRL_A, 32'h0001_5A20, r);
    measure(0, 40, 8'h20, 8'h5A, ca, cd, cdir, cio, crd, cwr, cm1);
    checks++;
    if (ca !== 16) begin errors++; $display("FAIL write_addr_clks: got %0d required 16", ca); end
    checks++;
    if (cd !== 16 || cdir !== 16) begin
      errors++; $display("FAIL write_data_clks: got %0d/%0d required 16/16", cd, cdir);
    end
    checks++;
    if (cwr !== 12 || cio !== 12) begin
      errors++; $display("FAIL write_strobe_clks: got wr=%0d io=%0d required 12/12", cwr, cio);
    end
    checks++;
    if (crd !== 0 || cm1 !== 0) begin
      errors++; $display("FAIL write_rd_m1: got rd=%0d m1=%0d required 0/0", crd, cm1);
    end
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL write_irq: got %b required 1", irq0); end
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0000_0002) begin errors++; $display("FAIL write_status: got %h required 00000002", r); end
  endtask

  task automatic test_read();
    logic [31:0] r;
    int ca, cd, cdir, cio, crd, cwr, cm1;
    din = 8'hC3;
    wb_xfer(0, 1, CTRL_A, 32'h0000_0041, r);
    measure(0, 40, 8'h41, 8'h00, ca, cd, cdir, cio, crd, cwr, cm1);
    checks++;
    if (crd !== 12 || cio !== 12) begin
      errors++; $display("FAIL read_strobe_clks: got rd=%0d io=%0d required 12/12", crd, cio);
    end
    checks++;
    if (ca !== 16 || cdir !== 0 || cwr !== 0) begin
      errors++; $display("FAIL read_addr_dir: got addr=%0d dir=%0d wr=%0d required 16/0/0", ca, cdir, cwr);
    end
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0000_C302) begin errors++; $display("FAIL read_status: got %h required 0000c302", r); end
    wb_xfer(0, 0, CTRL_A, 32'h0, r);
    checks++;
    if (r !== 32'h0000_0041) begin errors++; $display("FAIL read_ctrl: got %h required 00000041", r); end
  endtask

  task automatic test_wait();
    logic [31:0] r;
    int cnt;
    din   = 8'hC3;
    wait0 = 1'b0;
    repeat (3) @(negedge clk);
    wb_xfer(0, 1, CTRL_A, 32'h0000_0041, r);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!rd0) cnt++;
      if (cnt == 17) wait0 = 1'b1;
      @(negedge clk);
    end
    wait0 = 1'b1;
    checks++;
    if (cnt !== 24) begin errors++; $display("FAIL wait_strobe_clks: got %0d required 24", cnt); end
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r[2] !== 1'b0) begin errors++; $display("FAIL wait_timeout_bit: got %b required 0", r[2]); end
    checks++;
    if (r !== 32'h0000_C302) begin errors++; $display("FAIL wait_status: got %h required 0000c302", r); end
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    int ca, cd, cdir, cio, crd, cwr, cm1;
    wait1 = 1'b0;
    repeat (3) @(negedge clk);
    wb_xfer(1, 1, CTRL_A, 32'h0001_7710, r);
    measure(1, 50, 8'h10, 8'h77, ca, cd, cdir, cio, crd, cwr, cm1);
    wait1 = 1'b1;
    checks++;
    if (cwr !== 20 || cio !== 20) begin
      errors++; $display("FAIL timeout_strobe_clks: got wr=%0d io=%0d required 20/20", cwr, cio);
    end
    checks++;
    if (ca !== 24 || cd !== 24) begin
      errors++; $display("FAIL timeout_addr_data: got %0d/%0d required 24/24", ca, cd);
    end
    wb_xfer(1, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0000_0006) begin errors++; $display("FAIL timeout_status: got %h required 00000006", r); end
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL timeout_irq: got %b required 1", irq1); end
    wb_xfer(1, 1, STAT_A, 32'h0000_000E, r);
    wb_xfer(1, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0 || irq1 !== 1'b0) begin
      errors++; $display("FAIL timeout_w1c: got %h irq=%b required 00000000 irq=0", r, irq1);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    int a33, a44, dAA, cwr;
    bit ack_seen;
    a33 = 0; a44 = 0; dAA = 0; cwr = 0; ack_seen = 1'b0;
    wb_xfer(0, 1, CTRL_A, 32'h0001_AA33, r);
    for (int i = 0; i < 40; i++) begin
      if (addr0 == 8'h33) a33++;
      if (addr0 == 8'h44) a44++;
      if (dir0 && dout0 == 8'hAA) dAA++;
      if (!wr0) cwr++;
      if (i == 6) begin
        wb0.wb_cyc_in = 1; wb0.wb_stb_in = 1; wb0.wb_we_in = 1;
        wb0.wb_addr_in = CTRL_A; wb0.wb_data_in = 32'h0001_5544;
      end
      if (i == 7) begin
        ack_seen = wb0.wb_ack_out;
        wb0.wb_cyc_in = 0; wb0.wb_stb_in = 0; wb0.wb_we_in = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (!ack_seen) begin errors++; $display("FAIL overrun_ack: got 0 required 1"); end
    checks++;
    if (a33 !== 16 || a44 !== 0 || dAA !== 16 || cwr !== 12) begin
      errors++; $display("FAIL overrun_pins: got a33=%0d a44=%0d dAA=%0d wr=%0d required 16/0/16/12",
                         a33, a44, dAA, cwr);
    end
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0000_C30A) begin errors++; $display("FAIL overrun_status: got %h required 0000c30a", r); end
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL overrun_irq: got %b required 1", irq0); end
    wb_xfer(0, 1, STAT_A, 32'h0000_000E, r);
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0000_C300 || irq0 !== 1'b0) begin
      errors++; $display("FAIL overrun_w1c: got %h irq=%b required 0000c300 irq=0", r, irq0);
    end
  endtask

  task automatic test_back_to_back();
    logic a1, a2, a3;
    @(negedge clk);
    wb0.wb_cyc_in = 1; wb0.wb_stb_in = 1; wb0.wb_we_in = 0; wb0.wb_addr_in = STAT_A;
    @(negedge clk); a1 = wb0.wb_ack_out;
    @(negedge clk); a2 = wb0.wb_ack_out;
    wb0.wb_cyc_in = 0; wb0.wb_stb_in = 0;
    @(negedge clk); a3 = wb0.wb_ack_out;
    checks++;
    if ({a1, a2, a3} !== 3'b100) begin
      errors++; $display("FAIL ack_pulse: got %b required 100", {a1, a2, a3});
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    wb_xfer(0, 1, UNM_A, 32'hFFFF_FFFF, r);
    wb_xfer(0, 0, UNM_A, 32'h0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h required 00000000", r); end
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0000_C300) begin errors++; $display("FAIL unmapped_status: got %h required 0000c300", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bit in_t2;
    int cio;
    in_t2 = 1'b0;
    wb_xfer(0, 1, CTRL_A, 32'h0001_5A20, r);
    for (int i = 0; i < 10 && !in_t2; i++) begin
      if (!io0) in_t2 = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!in_t2) begin errors++; $display("FAIL midreset_t2_reached: ioreq=%b required 0", io0); end
    reset_b = 1'b0;
    #1;
    checks++;
    if ({io0, rd0, wr0, m10, dir0} !== 5'b11110 || addr0 !== 8'h00) begin
      errors++; $display("FAIL midreset_release: got pins=%b addr=%h required 11110 addr=00",
                         {io0, rd0, wr0, m10, dir0}, addr0);
    end
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    cio = 0;
    for (int i = 0; i < 30; i++) begin
      if (!io0) cio++;
      @(negedge clk);
    end
    checks++;
    if (cio !== 0 || irq0 !== 1'b0) begin
      errors++; $display("FAIL midreset_no_resume: got io_clks=%0d irq=%b required 0/0", cio, irq0);
    end
    wb_xfer(0, 0, STAT_A, 32'h0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h required 00000000", r); end
  endtask

  initial begin
    wb0.wb_cyc_in = 0; wb0.wb_stb_in = 0; wb0.wb_we_in = 0; wb0.wb_addr_in = '0; wb0.wb_data_in = '0;
    wb1.wb_cyc_in = 0; wb1.wb_stb_in = 0; wb1.wb_we_in = 0; wb1.wb_addr_in = '0; wb1.wb_data_in = '0;
    din = 8'h00; wait0 = 1'b1; wait1 = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_wait();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/z80_io_master.md
Z80_IO_MASTER -- requirements
Module: z80_io_master

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, 32'h3000_0000, Wishbone register base.
REQ-002 SHALL have parameter T_CLKS, 4, clk cycles per Z80 T-state (legal range 3..255).
REQ-003 SHALL have parameter WAIT_LIMIT, 255, maximum extra wait T-states before timeout.
REQ-004 SHALL have ports: clk  in  1  single clock (Wishbone domain); reset_b  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: wb_cyc_in, wb_stb_in, wb_we_in  in  1 each; wb_addr_in, wb_data_in  in  32; wb_ack_out  out  1; wb_data_out  out  32.
REQ-006 SHALL have port irq_out  out  1  high while DONE is set.
REQ-007 SHALL have Z80 pins: z80_address_bus out 8; z80_data_bus_out out 8; z80_data_bus_in in 8; z80_bus_dir out 1 (1 = driving data).
REQ-008 SHALL have Z80 pins: z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b, z80_m1_b  out  1 each (active low); z80_wait_b  in  1.

Function
REQ-009 SHALL decode CTRL at BASE_ADDRESS and STATUS at BASE_ADDRESS+4; other addresses ack, read 0, ignore writes.
REQ-010 SHALL assert wb_ack_out for exactly one clk, one clk after cyc&stb, and never on back-to-back clks for one request.
REQ-011 SHALL read CTRL as {15'b0, WR[16], DATA[15:8], PORT[7:0]} as last written.
REQ-012 SHALL read STATUS as {16'b0, RDATA[15:8], 4'b0, OVERRUN[3], TIMEOUT[2], DONE[1], BUSY[0]}.
REQ-013 SHALL, on a CTRL write when idle, latch PORT/DATA/WR, set BUSY, clear DONE/TIMEOUT, and enter T1 the next clk.
REQ-014 SHALL, on a CTRL write while BUSY, leave the cycle untouched and set OVERRUN.
REQ-015 SHALL, on a STATUS write, clear each of DONE, TIMEOUT, OVERRUN whose data bit is 1 (W1C).
REQ-016 SHALL sequence IDLE->T1->T2->TW->T3->IDLE, each state lasting T_CLKS clks.
REQ-017 SHALL drive z80_address_bus = PORT from T1 entry through T3 end, else 8'h00.
REQ-018 SHALL assert z80_ioreq_b and the selected strobe (read or write) low from T2 entry through T3 end.
REQ-019 SHALL, for writes, drive z80_bus_dir=1 and z80_data_bus_out=DATA from T1 entry through T3 end, else 0.
REQ-020 SHALL, at the last clk of each TW, sample synchronised wait_b: low -> repeat TW; high -> T3.
REQ-021 SHALL, after WAIT_LIMIT repeated TW states, go to T3 regardless of wait and set TIMEOUT.
REQ-022 SHALL, for reads, capture z80_data_bus_in into RDATA on the last clk of T3.
REQ-023 SHALL, on T3->IDLE, clear BUSY and set DONE in the same clk; a CTRL write that clk counts as busy.
REQ-024 SHALL hold z80_m1_b high at all times.

Reset
REQ-025 SHALL, while reset_b low, force IDLE, all strobes and z80_m1_b high, bus_dir 0, address/data outputs 0, all status bits, RDATA, CTRL and ack 0, irq_out 0.
REQ-026 SHALL, on reset mid-cycle, release strobes immediately (asynchronously) without completing the cycle or setting DONE.

Structure
REQ-027 SHALL place state enum, register offsets and STATUS/CTRL bit positions in shared package z80_io_pkg.
REQ-028 SHALL synchronise z80_wait_b through a two-flop sub-module z80_io_sync (reset value 1).

Verification
REQ-029 T_CLKS=4, write CTRL=0x1_5A_20 -> address 0x20, data 0x5A driven 16 clks, write strobe/ioreq low 12 clks, DONE=1, irq_out=1.
REQ-030 Write CTRL=0x00_00_41, data_in=0xC3 -> read strobe low 12 clks, STATUS reads 0x0000_C302 after completion.
REQ-031 Hold wait_b low 3 TW-states during a read -> strobes low 24 clks, TIMEOUT=0.
REQ-032 WAIT_LIMIT=2, wait_b held low -> cycle ends after 2 extra TW, STATUS bits TIMEOUT=1, DONE=1.
REQ-033 CTRL write while BUSY -> OVERRUN=1, pins unchanged; STATUS write 0xE clears DONE, TIMEOUT, OVERRUN and irq_out.
REQ-034 Assert reset_b low during T2 -> all strobes high same clk, STATUS reads 0 after release.
